bpm_tx_link_arbiter: RTL and testbench

Packet-level round-robin arbiter sharing the single Aurora BPM test-link AXI-Stream TX channel between `NPORTS` packet sources (test-pattern writer, diagnostic injectors). It sits between the sources and the Aurora TX user interface in the `auroraUserClk` domain. It never interleaves packets and enforces a per-port packet quota per FA interval. It also reports per-port packet counts for the last completed FA interval.

---
 rtl/bpm_link_pkg.sv | 11 +
 rtl/rr_picker.sv | 28 ++
 rtl/bpm_tx_link_arbiter.sv | 134 +++++++++++++
 tb/tb_bpm_tx_link_arbiter.sv | 545 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpm_link_pkg.sv
// Shared definitions for the BPM test-link arbiters: FSM state type and link width.
package bpm_link_pkg;

  localparam int BPM_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } link_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first eligible port strictly after `last`, wrapping.
module rr_picker #(
  parameter int NPORTS = 2
) (
  input  logic [NPORTS-1:0]         eligible,
  input  logic [$clog2(NPORTS)-1:0] last,
  output logic [NPORTS-1:0]         pick,
  output logic                      any
);

  localparam int IDX_W = $clog2(NPORTS);

  logic [IDX_W-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      idx = IDX_W'((int'(last) + k) % NPORTS);
      if (!any && eligible[idx]) begin
        pick[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bpm_tx_link_arbiter.sv
// Packet-level round-robin arbiter for the Aurora BPM test-link TX stream, with a
// per-port packet quota per FA interval and per-interval packet count reporting.
module bpm_tx_link_arbiter
  import bpm_link_pkg::*;
#(
  parameter int NPORTS          = 2,
  parameter int DATA_WIDTH      = BPM_DATA_WIDTH,
  parameter int MAX_PKTS_PER_FA = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                         auroraUserClk,
  input  logic                         auroraUserReset_n,
  input  logic                         auroraFAstrobe,
  input  logic [NPORTS-1:0]            enableMask,
  input  logic [NPORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NPORTS-1:0]            s_tvalid,
  input  logic [NPORTS-1:0]            s_tlast,
  output logic [NPORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]        BPM_TEST_AXI_STREAM_TX_tdata,
  output logic                         BPM_TEST_AXI_STREAM_TX_tvalid,
  output logic                         BPM_TEST_AXI_STREAM_TX_tlast,
  input  logic                         BPM_TEST_AXI_STREAM_TX_tready,
  output logic [NPORTS-1:0]            grant,
  output logic                         busy,
  output logic [NPORTS*CNT_WIDTH-1:0]  pktCount
);

  localparam int                   IDX_W    = $clog2(NPORTS);
  localparam logic [CNT_WIDTH-1:0] QUOTA    = CNT_WIDTH'(MAX_PKTS_PER_FA);
  localparam logic [IDX_W-1:0]     LAST_RST = IDX_W'(NPORTS - 1);

  link_state_e                        state_q, state_d;
  logic [NPORTS-1:0]                  grant_q, grant_d;
  logic [IDX_W-1:0]                   last_q, last_d, pick_idx;
  logic [NPORTS-1:0]                  eligible, pick, done;
  logic                               any;
  logic                               fire_last;
  logic [NPORTS-1:0][CNT_WIDTH-1:0]   cnt_q, pkt_count_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v >= QUOTA) ? QUOTA : v + 1'b1;
  endfunction

  // Arbitration: eligibility, round-robin pick and FSM
  always_comb begin
    for (int i = 0; i < NPORTS; i++)
      eligible[i] = s_tvalid[i] & enableMask[i] & (cnt_q[i] < QUOTA);
  end

  rr_picker #(
    .NPORTS(NPORTS)
  ) u_picker (
    .eligible(eligible),
    .last    (last_q),
    .pick    (pick),
    .any     (any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NPORTS; i++)
      if (pick[i]) pick_idx = IDX_W'(i);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = XFER;
          grant_d = pick;
          last_d  = pick_idx;
        end
      end
      XFER: begin
        if (fire_last) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge auroraUserClk or negedge auroraUserReset_n) begin
    if (!auroraUserReset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Output mux: grant is all-zero outside XFER, so the link idles at zero for free
  always_comb begin
    BPM_TEST_AXI_STREAM_TX_tdata = '0;
    for (int i = 0; i < NPORTS; i++)
      if (grant_q[i]) BPM_TEST_AXI_STREAM_TX_tdata = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign BPM_TEST_AXI_STREAM_TX_tvalid = |(s_tvalid & grant_q);
  assign BPM_TEST_AXI_STREAM_TX_tlast  = |(s_tlast & grant_q);
  assign s_tready  = grant_q & {NPORTS{BPM_TEST_AXI_STREAM_TX_tready}};
  assign fire_last = BPM_TEST_AXI_STREAM_TX_tvalid & BPM_TEST_AXI_STREAM_TX_tready &
                     BPM_TEST_AXI_STREAM_TX_tlast;
  assign done      = grant_q & {NPORTS{fire_last}};
  assign grant     = grant_q;
  assign busy      = (state_q == XFER);

  // Quota counters and FA-interval latch; a packet ending on the strobe counts in the closing interval
  always_ff @(posedge auroraUserClk or negedge auroraUserReset_n) begin
    if (!auroraUserReset_n) begin
      cnt_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (auroraFAstrobe) begin
          pkt_count_q[i] <= done[i] ? sat_inc(cnt_q[i]) : cnt_q[i];
          cnt_q[i]       <= '0;
        end else if (done[i]) begin
          cnt_q[i] <= sat_inc(cnt_q[i]);
        end
      end
    end
  end

  assign pktCount = pkt_count_q;

endmodule

// File: tb/tb_bpm_tx_link_arbiter.sv
// Randomized bench for bpm_tx_link_arbiter: queue-based sources, beat log and packet-level model.
module tb_bpm_tx_link_arbiter;

  localparam int NP = 2;
  localparam int DW = 32;
  localparam int MAXP = 4;
  localparam int CW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fa;
  logic [NP-1:0]    en_mask;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]    s_tvalid;
  logic [NP-1:0]    s_tlast;
  logic [NP-1:0]    s_tready;
  logic [DW-1:0]    tx_tdata;
  logic             tx_tvalid;
  logic             tx_tlast;
  logic             tx_tready;
  logic [NP-1:0]    grant;
  logic             busy;
  logic [NP*CW-1:0] pkt_count;

  always #5 clk = ~clk;

  bpm_tx_link_arbiter #(
    .NPORTS(NP), .DATA_WIDTH(DW), .MAX_PKTS_PER_FA(MAXP), .CNT_WIDTH(CW)
  ) dut (
    .auroraUserClk                (clk),
    .auroraUserReset_n            (rst_n),
    .auroraFAstrobe               (fa),
    .enableMask                   (en_mask),
    .s_tdata                      (s_tdata),
    .s_tvalid                     (s_tvalid),
    .s_tlast                      (s_tlast),
    .s_tready                     (s_tready),
    .BPM_TEST_AXI_STREAM_TX_tdata (tx_tdata),
    .BPM_TEST_AXI_STREAM_TX_tvalid(tx_tvalid),
    .BPM_TEST_AXI_STREAM_TX_tlast (tx_tlast),
    .BPM_TEST_AXI_STREAM_TX_tready(tx_tready),
    .grant                        (grant),
    .busy                         (busy),
    .pktCount                     (pkt_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int gap_pct = 0;
  int ready_pct = 100;
  int strobe_period = 0;
  int cyc = 0;
  int drops = 0;
  int seq [NP];
  logic [NP-1:0] src_fire = '0;
  bit pend = 0;
  beat_t srcq [NP][$];
  beat_t expq [NP][$];
  beat_t link_log [$];
  logic [NP-1:0] link_gnt [$];
  int link_cyc [$];
  logic [NP-1:0] grant_log [$];

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (!(s_tvalid[i] && !src_fire[i]))
        s_tvalid[i] = (srcq[i].size() > 0) && ($urandom_range(99) >= gap_pct);
      if (srcq[i].size() == 0) s_tvalid[i] = 1'b0;
      if (s_tvalid[i]) begin
        s_tdata[i*DW +: DW] = srcq[i][0].d;
        s_tlast[i] = srcq[i][0].l;
      end else begin
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i] = 1'b0;
      end
    end
    tx_tready = ($urandom_range(99) < ready_pct);
    fa = (strobe_period != 0) && (cyc % strobe_period == 0);
  endtask

  task automatic enqueue(input int p, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = {4'(p), 28'(seq[p])};
      b.l = (k == len - 1);
      seq[p]++;
      srcq[p].push_back(b);
      expq[p].push_back(b);
    end
    drive();
  endtask

  task automatic tick_sample();
    @(negedge clk);
    grant_log.push_back(grant);
    src_fire = s_tvalid & s_tready;
    if (pend && !tx_tvalid) drops++;
    pend = tx_tvalid && !tx_tready;
    if (tx_tvalid && tx_tready) begin
      link_log.push_back('{tx_tdata, tx_tlast});
      link_gnt.push_back(grant);
      link_cyc.push_back(cyc);
    end
  endtask

  task automatic tick_advance();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NP; i++)
      if (src_fire[i]) void'(srcq[i].pop_front());
    drive();
    src_fire = '0;
  endtask

  task automatic tick();
    tick_sample();
    tick_advance();
  endtask

  task automatic run_drain(input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound && !ok; n++) begin
      tick();
      if (srcq[0].size() == 0 && srcq[1].size() == 0 && !busy) ok = 1'b1;
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NP; i++) begin
      srcq[i].delete();
      expq[i].delete();
    end
    link_log.delete();
    link_gnt.delete();
    link_cyc.delete();
    grant_log.delete();
    src_fire = '0;
    pend = 0;
    drops = 0;
    drive();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    src_fire = '0;
    pend = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int count_tlast();
    int n = 0;
    foreach (link_log[k]) if (link_log[k].l) n++;
    return n;
  endfunction

  task automatic test_reset();
    reset_model();
    en_mask = '1;
    rst_n = 1'b0;
    enqueue(0, 2);
    enqueue(1, 2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (grant !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ctrl: grant=%b busy=%b, expected 00/0", grant, busy);
    end
    vectors++;
    if ({tx_tvalid, tx_tlast, tx_tdata} !== '0 || s_tready !== '0) begin
      miscompares++;
      $display("FAIL rst_link: tvalid=%b tlast=%b tdata=%h s_tready=%b, expected all 0",
               tx_tvalid, tx_tlast, tx_tdata, s_tready);
    end
    vectors++;
    if (pkt_count !== '0) begin
      miscompares++;
      $display("FAIL rst_pktcount: got %h, expected 0", pkt_count);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (grant_log[0] !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_first_grant: got %b, expected 01", grant_log[0]);
    end
    begin
      bit ok;
      run_drain(50, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL rst_drain: timeout, link beats %0d", link_log.size());
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    int n01, nother;
    reset_model();
    fa = 1'b1;
    tick();
    grant_log.delete();
    enqueue(0, 3);
    run_drain(50, ok);
    vectors++;
    if (!ok || link_log.size() != 3) begin
      miscompares++;
      $display("FAIL single_len: got %0d beats (drained=%0d), expected 3", link_log.size(), ok);
    end
    for (int k = 0; k < 3 && k < link_log.size(); k++) begin
      vectors++;
      if (link_log[k] !== expq[0][k]) begin
        miscompares++;
        $display("FAIL single_beat%0d: got %h, expected %h", k, link_log[k], expq[0][k]);
      end
    end
    n01 = 0;
    nother = 0;
    foreach (grant_log[k]) begin
      if (grant_log[k] == 2'b01) n01++;
      else if (grant_log[k] != 2'b00) nother++;
    end
    vectors++;
    if (n01 != 3 || nother != 0) begin
      miscompares++;
      $display("FAIL single_grant: 01 for %0d cycles, other %0d, expected 3/0", n01, nother);
    end
    fa = 1'b1;
    tick();
    vectors++;
    if (pkt_count !== 16'h0001) begin
      miscompares++;
      $display("FAIL single_pktcount: got %h, expected 0001", pkt_count);
    end
  endtask

  task automatic test_contention();
    bit ok;
    int left [NP];
    int lastp, nxt, f;
    beat_t exp_beats [$];
    logic [NP-1:0] exp_gnt [$];
    reset_model();
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      enqueue(0, 2);
      enqueue(1, 2);
    end
    run_drain(100, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL ctn_drain: timeout, link beats %0d", link_log.size());
    end
    for (int i = 0; i < NP; i++) left[i] = 2;
    lastp = NP - 1;
    for (int n = 0; n < 4; n++) begin
      nxt = -1;
      for (int k = 1; k <= NP; k++)
        if (nxt < 0 && left[(lastp + k) % NP] > 0) nxt = (lastp + k) % NP;
      left[nxt]--;
      lastp = nxt;
      for (int b = 0; b < 2; b++) begin
        exp_beats.push_back(expq[nxt].pop_front());
        exp_gnt.push_back(NP'(1) << nxt);
      end
      if (n < 3) exp_gnt.push_back('0);
    end
    foreach (exp_beats[k]) begin
      vectors++;
      if (k >= link_log.size() || link_log[k] !== exp_beats[k]) begin
        miscompares++;
        $display("FAIL ctn_beat%0d: got %h, expected %h", k,
                 (k < link_log.size()) ? link_log[k] : '0, exp_beats[k]);
      end
    end
    f = 0;
    while (f < grant_log.size() && grant_log[f] == '0) f++;
    foreach (exp_gnt[j]) begin
      vectors++;
      if (f + j >= grant_log.size() || grant_log[f+j] !== exp_gnt[j]) begin
        miscompares++;
        $display("FAIL ctn_grant%0d: got %b, expected %b", j,
                 (f + j < grant_log.size()) ? grant_log[f+j] : 2'bxx, exp_gnt[j]);
      end
    end
  endtask

  task automatic test_quota();
    bit ok;
    int sc;
    reset_model();
    fa = 1'b1;
    tick();
    for (int n = 0; n < 6; n++) enqueue(0, 2);
    repeat (40) tick();
    vectors++;
    if (count_tlast() != MAXP || busy !== 1'b0 || grant !== '0) begin
      miscompares++;
      $display("FAIL quota_block: %0d packets busy=%b grant=%b, expected %0d/0/00",
               count_tlast(), busy, grant, MAXP);
    end
    sc = cyc;
    fa = 1'b1;
    tick();
    vectors++;
    if (pkt_count[CW-1:0] !== CW'(MAXP)) begin
      miscompares++;
      $display("FAIL quota_pktcount: got %0d, expected %0d", pkt_count[CW-1:0], MAXP);
    end
    run_drain(100, ok);
    vectors++;
    if (!ok || link_log.size() != 12) begin
      miscompares++;
      $display("FAIL quota_total: got %0d beats (drained=%0d), expected 12", link_log.size(), ok);
    end
    vectors++;
    if (link_cyc.size() < 9 || link_cyc[8] <= sc) begin
      miscompares++;
      $display("FAIL quota_fifth: fifth packet at cycle %0d, expected after strobe cycle %0d",
               (link_cyc.size() > 8) ? link_cyc[8] : -1, sc);
    end
    foreach (link_log[k]) begin
      vectors++;
      if (k >= expq[0].size() || link_log[k] !== expq[0][k]) begin
        miscompares++;
        $display("FAIL quota_beat%0d: got %h", k, link_log[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int total, p, cur;
    bit in_pkt;
    beat_t e;
    reset_model();
    ready_pct = 50;
    gap_pct = 25;
    strobe_period = 16;
    total = 0;
    while (total < 1000) begin
      p = $urandom_range(NP - 1);
      cur = $urandom_range(6, 1);
      enqueue(p, cur);
      total += cur;
    end
    run_drain(30000, ok);
    vectors++;
    if (!ok || link_log.size() != total) begin
      miscompares++;
      $display("FAIL bp_count: got %0d beats (drained=%0d), expected %0d", link_log.size(), ok, total);
    end
    vectors++;
    if (drops != 0) begin
      miscompares++;
      $display("FAIL bp_valid_drop: got %0d drops, expected 0", drops);
    end
    in_pkt = 0;
    cur = 0;
    foreach (link_log[k]) begin
      p = int'(link_log[k].d[DW-1:DW-4]);
      vectors++;
      if (p >= NP || link_gnt[k] !== (NP'(1) << p) || (in_pkt && p != cur)) begin
        miscompares++;
        $display("FAIL bp_port%0d: data %h grant %b open-packet port %0d", k, link_log[k].d, link_gnt[k], cur);
      end else begin
        e = expq[p].pop_front();
        vectors++;
        if (link_log[k] !== e) begin
          miscompares++;
          $display("FAIL bp_beat%0d: got %h, expected %h", k, link_log[k], e);
        end
      end
      cur = p;
      in_pkt = !link_log[k].l;
    end
    ready_pct = 100;
    gap_pct = 0;
    strobe_period = 0;
  endtask

  task automatic test_strobe_final_beat();
    bit ok, hit;
    reset_model();
    fa = 1'b1;
    tick();
    enqueue(1, 3);
    hit = 0;
    for (int n = 0; n < 30 && !hit; n++) begin
      tick_sample();
      if (tx_tvalid && tx_tready && tx_tlast) begin
        fa = 1'b1;
        hit = 1;
      end
      tick_advance();
    end
    vectors++;
    if (!hit || pkt_count !== 16'h0100) begin
      miscompares++;
      $display("FAIL sfb_pktcount: got %h (hit=%0d), expected 0100", pkt_count, hit);
    end
    for (int n = 0; n < 5; n++) enqueue(1, 2);
    repeat (40) tick();
    vectors++;
    if (count_tlast() != 1 + MAXP) begin
      miscompares++;
      $display("FAIL sfb_new_interval: got %0d packets, expected %0d", count_tlast(), 1 + MAXP);
    end
    fa = 1'b1;
    tick();
    vectors++;
    if (pkt_count[2*CW-1:CW] !== CW'(MAXP)) begin
      miscompares++;
      $display("FAIL sfb_pktcount2: got %0d, expected %0d", pkt_count[2*CW-1:CW], MAXP);
    end
    run_drain(100, ok);
  endtask

  task automatic test_enable_mid_packet();
    bit ok;
    int n01;
    reset_model();
    fa = 1'b1;
    tick();
    en_mask = 2'b11;
    enqueue(0, 4);
    enqueue(0, 2);
    enqueue(0, 2);
    for (int n = 0; n < 20 && link_log.size() == 0; n++) tick();
    en_mask = 2'b10;
    grant_log.delete();
    repeat (30) tick();
    vectors++;
    if (link_log.size() != 4) begin
      miscompares++;
      $display("FAIL en_len: got %0d beats, expected 4", link_log.size());
    end
    for (int k = 0; k < 4 && k < link_log.size(); k++) begin
      vectors++;
      if (link_log[k] !== expq[0][k]) begin
        miscompares++;
        $display("FAIL en_beat%0d: got %h, expected %h", k, link_log[k], expq[0][k]);
      end
    end
    n01 = 0;
    foreach (grant_log[k]) if (grant_log[k] != '0) n01++;
    vectors++;
    if (n01 != 3) begin
      miscompares++;
      $display("FAIL en_no_regrant: got %0d granted cycles, expected 3", n01);
    end
    en_mask = 2'b11;
    run_drain(100, ok);
    vectors++;
    if (!ok || link_log.size() != 8) begin
      miscompares++;
      $display("FAIL en_resume: got %0d beats (drained=%0d), expected 8", link_log.size(), ok);
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok, hit;
    reset_model();
    en_mask = 2'b11;
    enqueue(0, 4);
    hit = 0;
    for (int n = 0; n < 20 && !hit; n++) begin
      tick_sample();
      if (link_log.size() == 2) hit = 1;
      else tick_advance();
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (!hit || grant !== '0 || busy !== 1'b0 || s_tready !== '0 ||
        {tx_tvalid, tx_tlast, tx_tdata} !== '0) begin
      miscompares++;
      $display("FAIL rmp_outputs: hit=%0d grant=%b busy=%b s_tready=%b tvalid=%b tlast=%b tdata=%h, expected 0",
               hit, grant, busy, s_tready, tx_tvalid, tx_tlast, tx_tdata);
    end
    src_fire = '0;
    pend = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    enqueue(1, 2);
    vectors++;
    if (pkt_count !== '0) begin
      miscompares++;
      $display("FAIL rmp_pktcount: got %h, expected 0", pkt_count);
    end
    grant_log.delete();
    tick();
    vectors++;
    if (grant_log[0] !== 2'b01) begin
      miscompares++;
      $display("FAIL rmp_first_grant: got %b, expected 01", grant_log[0]);
    end
    run_drain(100, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rmp_drain: timeout");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fa = 1'b0;
    en_mask = '1;
    s_tvalid = '0;
    s_tlast = '0;
    s_tdata = '0;
    tx_tready = 1'b1;
    for (int i = 0; i < NP; i++) seq[i] = 0;
    test_reset();
    test_single();
    test_contention();
    test_quota();
    test_backpressure();
    test_strobe_final_beat();
    test_enable_mid_packet();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
